quotient_collector: RTL and testbench

Gathers per-lane results from the parallel divider bank and turns them into one registered frame. Each lane reports its own `data_valid_out` pulse, so lanes may finish on different cycles. The block captures every lane's quotient and remainder, optionally rounds to nearest, and presents the complete frame of SIZE coordinates to the downstream projection stage over a valid/ready handshake. Incomplete frames are dropped on timeout, and lane pulses that arrive when they cannot be accepted are flagged.

---
 rtl/quotient_collector.sv | 140 ++++++++++++++
 tb/tb_quotient_collector.sv | 436 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/quotient_collector.sv
// quotient_collector: gathers per-lane divider results (optionally rounded to
// nearest) into one registered SIZE-lane frame and hands it downstream over a
// valid/ready handshake. Stale frames time out; rejected strobes flag overrun.
module quotient_collector #(
   parameter int unsigned SIZE    = 6,
   parameter int unsigned WIDTH   = 9,
   parameter int unsigned ROUND   = 1,
   parameter int unsigned TIMEOUT = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] quotient_in  [SIZE],
   input  logic [WIDTH-1:0] remainder_in [SIZE],
   input  logic [WIDTH-1:0] divisor_in   [SIZE/2],
   input  logic [SIZE-1:0]  valid_in,
   output logic [WIDTH-1:0] quotient_out [SIZE],
   output logic             frame_valid_out,
   input  logic             frame_ready_in,
   output logic [SIZE-1:0]  lane_mask_out,
   output logic             timeout_out,
   output logic             overrun_out
);

   localparam int unsigned      CNT_W    = $clog2(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      PRESENT = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [SIZE-1:0]  mask_q, mask_d;
   logic [WIDTH-1:0] data_q [SIZE];
   logic [WIDTH-1:0] data_d [SIZE];
   logic             frame_valid_q, frame_valid_d;
   logic             timeout_q, timeout_d;
   logic             overrun_q, overrun_d;

   logic [WIDTH-1:0] lane_val [SIZE];
   logic [SIZE-1:0]  capture;
   logic             mask_full;
   logic             cnt_last;

   // Per-lane round-to-nearest: 2*rem >= div compared at WIDTH+1 bits, saturating
   for (genvar g = 0; g < SIZE; g++) begin : g_lane
      logic [WIDTH:0] rem_x2;
      logic [WIDTH:0] div_x;
      logic           round_up;

      assign rem_x2      = {remainder_in[g], 1'b0};
      assign div_x       = {1'b0, divisor_in[g/2]};
      assign round_up    = (ROUND != 0) && (divisor_in[g/2] != '0) && (rem_x2 >= div_x);
      assign lane_val[g] = (round_up && (quotient_in[g] != '1)) ? quotient_in[g] + WIDTH'(1)
                                                                 : quotient_in[g];
   end

   // A lane is taken once per frame and never while a frame is being presented
   assign capture   = (state_q == PRESENT) ? '0 : (valid_in & ~mask_q);
   assign mask_full = &(mask_q | capture);
   assign cnt_last  = (cnt_q == CNT_LAST);

   // State register
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic; completion has priority over timeout
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (capture != '0) state_d = mask_full ? PRESENT : COLLECT;
         end
         COLLECT: begin
            if (mask_full)     state_d = PRESENT;
            else if (cnt_last) state_d = IDLE;
         end
         PRESENT: begin
            if (frame_ready_in) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Next values for the lane data, mask, dwell counter and status outputs
   always_comb begin
      cnt_d     = '0;
      mask_d    = mask_q | capture;
      timeout_d = 1'b0;
      overrun_d = |(valid_in & ~capture);
      data_d    = data_q;
      for (int i = 0; i < SIZE; i++) begin
         if (capture[i]) data_d[i] = lane_val[i];
      end
      case (state_q)
         COLLECT: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (!mask_full && cnt_last) begin
               mask_d    = '0;
               timeout_d = 1'b1;
            end
         end
         PRESENT: begin
            if (frame_ready_in) mask_d = '0;
         end
         default: ;
      endcase
      frame_valid_d = (state_d == PRESENT);
   end

   // Datapath and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q         <= '0;
         mask_q        <= '0;
         frame_valid_q <= 1'b0;
         timeout_q     <= 1'b0;
         overrun_q     <= 1'b0;
         for (int i = 0; i < SIZE; i++) data_q[i] <= '0;
      end else begin
         cnt_q         <= cnt_d;
         mask_q        <= mask_d;
         frame_valid_q <= frame_valid_d;
         timeout_q     <= timeout_d;
         overrun_q     <= overrun_d;
         for (int i = 0; i < SIZE; i++) data_q[i] <= data_d[i];
      end
   end

   assign quotient_out    = data_q;
   assign frame_valid_out = frame_valid_q;
   assign lane_mask_out   = mask_q;
   assign timeout_out     = timeout_q;
   assign overrun_out     = overrun_q;

endmodule

// File: tb/tb_quotient_collector.sv
// Bench for quotient_collector: a truncating and a rounding instance share the
// same stimulus and are compared against a frame-level reference model.
module tb_quotient_collector;

   localparam int unsigned SIZE    = 6;
   localparam int unsigned WIDTH   = 9;
   localparam int unsigned TIMEOUT = 8;
   localparam int          MAXV    = 511;

   logic             clk = 1'b0;
   logic             rst;
   logic [WIDTH-1:0] q_in [SIZE];
   logic [WIDTH-1:0] r_in [SIZE];
   logic [WIDTH-1:0] d_in [SIZE/2];
   logic [SIZE-1:0]  v_in;
   logic             rdy;
   logic [WIDTH-1:0] qo_t [SIZE];
   logic [WIDTH-1:0] qo_r [SIZE];
   logic             fv_t, fv_r, to_t, to_r, ov_t, ov_r;
   logic [SIZE-1:0]  mk_t, mk_r;

   // Reference model state
   bit               m_present;
   logic [SIZE-1:0]  m_mask;
   int               m_first;
   int               m_dt [SIZE];
   int               m_dr [SIZE];
   bit               e_to, e_ov;
   int               cyc;
   int               checks, errors;

   always #5 clk = ~clk;

   quotient_collector #(.SIZE(SIZE), .WIDTH(WIDTH), .ROUND(0), .TIMEOUT(TIMEOUT)) u_trunc (
      .clk(clk), .rst(rst), .quotient_in(q_in), .remainder_in(r_in), .divisor_in(d_in),
      .valid_in(v_in), .quotient_out(qo_t), .frame_valid_out(fv_t), .frame_ready_in(rdy),
      .lane_mask_out(mk_t), .timeout_out(to_t), .overrun_out(ov_t));

   quotient_collector #(.SIZE(SIZE), .WIDTH(WIDTH), .ROUND(1), .TIMEOUT(TIMEOUT)) u_round (
      .clk(clk), .rst(rst), .quotient_in(q_in), .remainder_in(r_in), .divisor_in(d_in),
      .valid_in(v_in), .quotient_out(qo_r), .frame_valid_out(fv_r), .frame_ready_in(rdy),
      .lane_mask_out(mk_r), .timeout_out(to_r), .overrun_out(ov_r));

   // Arithmetic definition of the captured lane value
   function automatic int round_ref(int q, int r, int d, bit rnd);
      if (rnd && d != 0 && 2 * r >= d) return (q + 1 > MAXV) ? MAXV : q + 1;
      return q;
   endfunction

   // Apply this cycle's inputs to the model, then advance one clock
   task automatic step();
      e_to = 1'b0;
      e_ov = 1'b0;
      if (rst) begin
         m_present = 1'b0;
         m_mask    = '0;
         for (int i = 0; i < SIZE; i++) begin
            m_dt[i] = 0;
            m_dr[i] = 0;
         end
      end else if (m_present) begin
         if (v_in != '0) e_ov = 1'b1;
         if (rdy) begin
            m_present = 1'b0;
            m_mask    = '0;
         end
      end else begin
         bit was_empty;
         was_empty = (m_mask == '0);
         for (int i = 0; i < SIZE; i++) begin
            if (v_in[i]) begin
               if (m_mask[i]) e_ov = 1'b1;
               else begin
                  m_mask[i] = 1'b1;
                  m_dt[i] = round_ref(int'(q_in[i]), int'(r_in[i]), int'(d_in[i/2]), 1'b0);
                  m_dr[i] = round_ref(int'(q_in[i]), int'(r_in[i]), int'(d_in[i/2]), 1'b1);
               end
            end
         end
         if (was_empty && m_mask != '0) m_first = cyc;
         if (m_mask == '1) m_present = 1'b1;
         else if (!was_empty && (cyc - m_first == int'(TIMEOUT))) begin
            m_mask = '0;
            e_to   = 1'b1;
         end
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic set_lane(int i, int q, int r);
      q_in[i] = WIDTH'(q);
      r_in[i] = WIDTH'(r);
   endtask

   task automatic randomize_lanes();
      for (int i = 0; i < SIZE; i++) set_lane(i, int'($urandom_range(0, MAXV)), int'($urandom_range(0, MAXV)));
   endtask

   task automatic randomize_divisors();
      for (int j = 0; j < SIZE/2; j++) d_in[j] = WIDTH'($urandom_range(0, MAXV));
   endtask

   task automatic test_reset();
      rst = 1'b1; v_in = '0; rdy = 1'b0;
      randomize_lanes(); randomize_divisors();
      step(); step();
      checks++;
      if (fv_t !== 1'b0 || fv_r !== 1'b0 || mk_t !== '0 || mk_r !== '0 ||
          to_t !== 1'b0 || to_r !== 1'b0 || ov_t !== 1'b0 || ov_r !== 1'b0) begin
         errors++;
         $display("FAIL reset_ctrl: got fv=%b/%b mask=%h/%h to=%b/%b ov=%b/%b, expected all 0",
                  fv_t, fv_r, mk_t, mk_r, to_t, to_r, ov_t, ov_r);
      end
      for (int i = 0; i < SIZE; i++) begin
         checks++;
         if (qo_t[i] !== '0 || qo_r[i] !== '0) begin
            errors++;
            $display("FAIL reset_data lane %0d: got %0d/%0d, expected 0", i, qo_t[i], qo_r[i]);
         end
      end
      rst = 1'b0;
   endtask

   task automatic test_simultaneous();
      step(); step();
      randomize_divisors();
      for (int i = 0; i < SIZE; i++) set_lane(i, i + 1, int'($urandom_range(0, MAXV)));
      v_in = '1; rdy = 1'b1;
      step();
      v_in = '0;
      checks++;
      if (fv_t !== 1'b1 || fv_r !== 1'b1) begin
         errors++;
         $display("FAIL simul_valid: got %b/%b, expected 1", fv_t, fv_r);
      end
      for (int i = 0; i < SIZE; i++) begin
         checks++;
         if (qo_t[i] !== WIDTH'(i + 1) || qo_r[i] !== WIDTH'(m_dr[i])) begin
            errors++;
            $display("FAIL simul_data lane %0d: got %0d/%0d, expected %0d/%0d", i, qo_t[i], qo_r[i], i + 1, m_dr[i]);
         end
      end
      step();
      checks++;
      if (fv_t !== 1'b0 || fv_r !== 1'b0 || mk_t !== '0 || mk_r !== '0) begin
         errors++;
         $display("FAIL simul_accept: got fv=%b/%b mask=%h/%h, expected fv=0 mask=0", fv_t, fv_r, mk_t, mk_r);
      end
      rdy = 1'b0;
   endtask

   task automatic test_staggered();
      logic [SIZE-1:0]  sched [8];
      logic [WIDTH-1:0] held  [SIZE];
      sched = '{6'h08, 6'h01, 6'h00, 6'h20, 6'h02, 6'h00, 6'h10, 6'h04};
      rdy = 1'b0;
      randomize_divisors();
      for (int j = 0; j < 8; j++) begin
         randomize_lanes();
         v_in = sched[j];
         step();
         v_in = '0;
         checks++;
         if (mk_t !== m_mask || mk_r !== m_mask || fv_t !== (j == 7) || fv_r !== (j == 7)) begin
            errors++;
            $display("FAIL stagger_step %0d: got mask=%h/%h fv=%b/%b, expected mask=%h fv=%b",
                     j, mk_t, mk_r, fv_t, fv_r, m_mask, (j == 7));
         end
      end
      for (int i = 0; i < SIZE; i++) begin
         held[i] = WIDTH'(m_dt[i]);
         checks++;
         if (qo_t[i] !== WIDTH'(m_dt[i]) || qo_r[i] !== WIDTH'(m_dr[i])) begin
            errors++;
            $display("FAIL stagger_data lane %0d: got %0d/%0d, expected %0d/%0d", i, qo_t[i], qo_r[i], m_dt[i], m_dr[i]);
         end
      end
      for (int k = 0; k < 4; k++) begin
         randomize_lanes();
         step();
         checks++;
         if (fv_t !== 1'b1 || fv_r !== 1'b1 || qo_t != held) begin
            errors++;
            $display("FAIL stagger_hold %0d: got fv=%b/%b lane0=%0d, expected fv=1 lane0=%0d", k, fv_t, fv_r, qo_t[0], held[0]);
         end
      end
      rdy = 1'b1;
      step();
      rdy = 1'b0;
      checks++;
      if (fv_t !== 1'b0 || fv_r !== 1'b0) begin
         errors++;
         $display("FAIL stagger_accept: got fv=%b/%b, expected 0", fv_t, fv_r);
      end
   endtask

   task automatic test_rounding();
      int fq [2][SIZE];
      int fr [2][SIZE];
      int fd [2][SIZE/2];
      int fe [2][SIZE];
      fq = '{'{10, 10, 511, 200, 37, 511}, '{50, 60, 70, 511, 5, 6}};
      fr = '{'{3, 2, 4, 1, 100, 511},      '{300, 199, 200, 255, 0, 1}};
      fd = '{'{5, 5, 0},                   '{400, 400, 1}};
      fe = '{'{11, 10, 511, 200, 37, 511}, '{51, 60, 71, 511, 5, 7}};
      for (int f = 0; f < 2; f++) begin
         for (int i = 0; i < SIZE; i++) set_lane(i, fq[f][i], fr[f][i]);
         for (int j = 0; j < SIZE/2; j++) d_in[j] = WIDTH'(fd[f][j]);
         v_in = '1; rdy = 1'b1;
         step();
         v_in = '0;
         for (int i = 0; i < SIZE; i++) begin
            checks++;
            if (fv_r !== 1'b1 || qo_r[i] !== WIDTH'(fe[f][i]) || qo_t[i] !== WIDTH'(fq[f][i])) begin
               errors++;
               $display("FAIL round f%0d lane %0d: got fv=%b round=%0d trunc=%0d, expected fv=1 round=%0d trunc=%0d",
                        f, i, fv_r, qo_r[i], qo_t[i], fe[f][i], fq[f][i]);
            end
         end
         step();
         rdy = 1'b0;
      end
   endtask

   task automatic test_timeout();
      rdy = 1'b0;
      randomize_lanes(); randomize_divisors();
      v_in = 6'h1f;
      step();
      v_in = '0;
      for (int k = 1; k <= int'(TIMEOUT) + 2; k++) begin
         bit exp_pulse;
         if (k > 1) step();
         exp_pulse = (k == int'(TIMEOUT) + 1);
         checks++;
         if (to_t !== exp_pulse || to_r !== exp_pulse || mk_t !== (k > int'(TIMEOUT) ? 6'h00 : 6'h1f) ||
             fv_t !== 1'b0 || mk_r !== mk_t) begin
            errors++;
            $display("FAIL timeout k=%0d: got to=%b/%b mask=%h/%h fv=%b, expected to=%b mask=%h fv=0",
                     k, to_t, to_r, mk_t, mk_r, fv_t, exp_pulse, (k > int'(TIMEOUT) ? 6'h00 : 6'h1f));
         end
      end
      // Full frame after the drop, then completion on the timeout cycle itself
      randomize_lanes();
      v_in = '1; rdy = 1'b1;
      step();
      v_in = '0;
      checks++;
      if (fv_t !== 1'b1 || qo_t[3] !== WIDTH'(m_dt[3]) || qo_r[5] !== WIDTH'(m_dr[5])) begin
         errors++;
         $display("FAIL timeout_next: got fv=%b l3=%0d l5=%0d, expected fv=1 l3=%0d l5=%0d", fv_t, qo_t[3], qo_r[5], m_dt[3], m_dr[5]);
      end
      step();
      rdy = 1'b0;
      v_in = 6'h1f;
      step();
      v_in = '0;
      for (int k = 0; k < int'(TIMEOUT) - 1; k++) step();
      v_in = 6'h20;
      step();
      v_in = '0;
      checks++;
      if (fv_t !== 1'b1 || fv_r !== 1'b1 || to_t !== 1'b0 || to_r !== 1'b0 || mk_t !== 6'h3f) begin
         errors++;
         $display("FAIL timeout_tie: got fv=%b/%b to=%b/%b mask=%h, expected fv=1 to=0 mask=3f", fv_t, fv_r, to_t, to_r, mk_t);
      end
      rdy = 1'b1;
      step();
      rdy = 1'b0;
   endtask

   task automatic test_overrun();
      int a, c;
      rdy = 1'b0;
      randomize_lanes(); randomize_divisors();
      a = int'($urandom_range(0, 255));
      set_lane(2, a, 0);
      v_in = 6'h04;
      step();
      checks++;
      if (ov_t !== 1'b0 || mk_t !== 6'h04) begin
         errors++;
         $display("FAIL ovr_first: got ov=%b mask=%h, expected ov=0 mask=04", ov_t, mk_t);
      end
      set_lane(2, a + 256, 0);
      v_in = 6'h05;
      step();
      checks++;
      if (ov_t !== 1'b1 || ov_r !== 1'b1 || mk_t !== 6'h05) begin
         errors++;
         $display("FAIL ovr_dup: got ov=%b/%b mask=%h, expected ov=1 mask=05", ov_t, ov_r, mk_t);
      end
      v_in = 6'h00;
      step();
      checks++;
      if (ov_t !== 1'b0 || ov_r !== 1'b0) begin
         errors++;
         $display("FAIL ovr_pulse: got ov=%b/%b, expected 0", ov_t, ov_r);
      end
      v_in = 6'h3a;
      step();
      checks++;
      if (fv_t !== 1'b1 || qo_t[2] !== WIDTH'(a) || qo_r[2] !== WIDTH'(m_dr[2]) || ov_t !== 1'b0) begin
         errors++;
         $display("FAIL ovr_keep: got fv=%b lane2=%0d/%0d ov=%b, expected fv=1 lane2=%0d/%0d ov=0",
                  fv_t, qo_t[2], qo_r[2], ov_t, a, m_dr[2]);
      end
      c = int'($urandom_range(0, MAXV));
      set_lane(0, c, 0);
      v_in = 6'h01; rdy = 1'b1;
      step();
      v_in = '0; rdy = 1'b0;
      checks++;
      if (ov_t !== 1'b1 || ov_r !== 1'b1 || fv_t !== 1'b0 || mk_t !== '0) begin
         errors++;
         $display("FAIL ovr_accept: got ov=%b/%b fv=%b mask=%h, expected ov=1 fv=0 mask=00", ov_t, ov_r, fv_t, mk_t);
      end
      randomize_lanes();
      v_in = 6'h3e;
      step();
      checks++;
      if (mk_t !== 6'h3e || mk_r !== 6'h3e || fv_t !== 1'b0 || ov_t !== 1'b0) begin
         errors++;
         $display("FAIL ovr_nocarry: got mask=%h/%h fv=%b ov=%b, expected mask=3e fv=0 ov=0", mk_t, mk_r, fv_t, ov_t);
      end
      c = int'($urandom_range(0, MAXV));
      set_lane(0, c, 0);
      v_in = 6'h01; rdy = 1'b1;
      step();
      v_in = '0;
      checks++;
      if (fv_t !== 1'b1 || qo_t[0] !== WIDTH'(c) || qo_r[0] !== WIDTH'(m_dr[0])) begin
         errors++;
         $display("FAIL ovr_next: got fv=%b lane0=%0d/%0d, expected fv=1 lane0=%0d/%0d", fv_t, qo_t[0], qo_r[0], c, m_dr[0]);
      end
      step();
      rdy = 1'b0;
   endtask

   task automatic test_reset_mid();
      rdy = 1'b0;
      randomize_lanes(); randomize_divisors();
      v_in = 6'h0b;
      step();
      v_in = '0;
      checks++;
      if (mk_t !== 6'h0b) begin
         errors++;
         $display("FAIL rstmid_pre: got mask=%h, expected 0b", mk_t);
      end
      rst = 1'b1;
      step();
      rst = 1'b0;
      checks++;
      if (fv_t !== 1'b0 || mk_t !== '0 || mk_r !== '0 || to_t !== 1'b0 || ov_t !== 1'b0 ||
          qo_t[0] !== '0 || qo_r[1] !== '0 || qo_t[3] !== '0) begin
         errors++;
         $display("FAIL rstmid_state: got fv=%b mask=%h/%h to=%b ov=%b l0=%0d l1=%0d l3=%0d, expected all 0",
                  fv_t, mk_t, mk_r, to_t, ov_t, qo_t[0], qo_r[1], qo_t[3]);
      end
      for (int k = 0; k < int'(TIMEOUT) + 3; k++) begin
         step();
         checks++;
         if (to_t !== 1'b0 || to_r !== 1'b0 || mk_t !== '0 || fv_t !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_quiet %0d: got to=%b/%b mask=%h fv=%b, expected 0", k, to_t, to_r, mk_t, fv_t);
         end
      end
      randomize_lanes();
      v_in = '1; rdy = 1'b1;
      step();
      v_in = '0;
      for (int i = 0; i < SIZE; i++) begin
         checks++;
         if (fv_t !== 1'b1 || qo_t[i] !== WIDTH'(m_dt[i]) || qo_r[i] !== WIDTH'(m_dr[i])) begin
            errors++;
            $display("FAIL rstmid_frame lane %0d: got fv=%b %0d/%0d, expected fv=1 %0d/%0d", i, fv_t, qo_t[i], qo_r[i], m_dt[i], m_dr[i]);
         end
      end
      step();
      rdy = 1'b0;
   endtask

   task automatic test_random();
      for (int n = 0; n < 600; n++) begin
         if (!m_present && m_mask == '0) randomize_divisors();
         randomize_lanes();
         v_in = SIZE'($urandom & $urandom);
         rdy  = ($urandom_range(0, 3) != 0);
         rst  = ($urandom_range(0, 99) == 0);
         step();
         checks++;
         if (fv_t !== m_present || fv_r !== m_present || mk_t !== m_mask || mk_r !== m_mask ||
             to_t !== e_to || to_r !== e_to || ov_t !== e_ov || ov_r !== e_ov) begin
            errors++;
            $display("FAIL random_ctrl n=%0d: got fv=%b/%b mask=%h/%h to=%b/%b ov=%b/%b, expected fv=%b mask=%h to=%b ov=%b",
                     n, fv_t, fv_r, mk_t, mk_r, to_t, to_r, ov_t, ov_r, m_present, m_mask, e_to, e_ov);
         end
         if (m_present) begin
            for (int i = 0; i < SIZE; i++) begin
               checks++;
               if (qo_t[i] !== WIDTH'(m_dt[i]) || qo_r[i] !== WIDTH'(m_dr[i])) begin
                  errors++;
                  $display("FAIL random_data n=%0d lane %0d: got %0d/%0d, expected %0d/%0d",
                           n, i, qo_t[i], qo_r[i], m_dt[i], m_dr[i]);
               end
            end
         end
      end
      rst = 1'b0;
      v_in = '0;
   endtask

   initial begin
      checks = 0; errors = 0; cyc = 0;
      m_present = 1'b0; m_mask = '0; m_first = 0; e_to = 1'b0; e_ov = 1'b0;
      for (int i = 0; i < SIZE; i++) begin
         m_dt[i] = 0;
         m_dr[i] = 0;
      end
      rst = 1'b1; v_in = '0; rdy = 1'b0;
      test_reset();
      test_simultaneous();
      test_staggered();
      test_rounding();
      test_timeout();
      test_overrun();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
